// File: rtl/jtframe_dipctl.sv
// jtframe_dipctl: OSD status / DIP-switch controller.
//
// The raw OSD status word is synchronised into clk, and a new value is committed to
// dip_cfg only once it has held steady for STABLE cycles. Core-facing settings (flip,
// rotation, HDMI aspect ratio, FX level, per-channel sound enables) are registered
// functions of the committed word. A pause FSM toggles on the pause button and only
// enters or leaves the paused state at a vertical-blank rising edge.
//
// Optional build macro:
//   JTFRAME_DIP_OSDPAUSE_EN  when defined, the core is held paused while the OSD is shown.
//
// Ports:
//   clk, rst       system clock, asynchronous active-high reset
//   status         raw OSD status word (asynchronous to clk)
//   core_mod       bit 0 set for a vertical game
//   game_pause     pause button level
//   vb             vertical blank (clk domain)
//   osd_shown      OSD visible (only used with JTFRAME_DIP_OSDPAUSE_EN)
//   dip_cfg        committed status word; cfg_upd pulses for one cycle when it changes
//   dip_flip, rotate, hdmi_arx, hdmi_ary, dip_fxlevel, snd_en   derived settings
//   dip_pause      active low: 0 means the core is paused
module jtframe_dipctl #(
   parameter int unsigned   SW      = 64,
   parameter int unsigned   SNDCH   = 2,
   parameter int unsigned   SND_LSB = 8,
   parameter int unsigned   STABLE  = 16,
   parameter logic [SW-1:0] RST_CFG = '0,
   parameter logic [12:0]   ARX     = 13'd4,
   parameter logic [12:0]   ARY     = 13'd3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [SW-1:0]    status,
   input  logic [6:0]       core_mod,
   input  logic             game_pause,
   input  logic             vb,
   input  logic             osd_shown,
   output logic [SW-1:0]    dip_cfg,
   output logic             cfg_upd,
   output logic             dip_flip,
   output logic [1:0]       rotate,
   output logic [12:0]      hdmi_arx,
   output logic [12:0]      hdmi_ary,
   output logic [1:0]       dip_fxlevel,
   output logic [SNDCH-1:0] snd_en,
   output logic             dip_pause
);

   localparam int unsigned   CW       = (STABLE > 1) ? $clog2(STABLE) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(STABLE - 1);

   // ---------------------------------------------------------------------------------------
   // Derived-setting functions, shared by the reset values and the running logic
   // ---------------------------------------------------------------------------------------
   function automatic logic [SNDCH-1:0] snd_of(input logic [SW-1:0] cfg);
      logic [SNDCH-1:0] en;
      en = '0;
      for (int i = 0; i < int'(SNDCH); i++) begin
         en[i] = ~cfg[SND_LSB + i];
      end
      return en;
   endfunction

   // ar==0 selects the native ratio (swapped for vertical games); otherwise ar-1 is a
   // preset index passed to the scaler with ary forced to zero.
   function automatic logic [12:0] arx_of(input logic [SW-1:0] cfg, input logic swap);
      logic [1:0] ar;
      ar = cfg[17:16];
      if (ar == 2'd0) return swap ? ARY : ARX;
      else            return {11'd0, ar - 2'd1};
   endfunction

   function automatic logic [12:0] ary_of(input logic [SW-1:0] cfg, input logic swap);
      if (cfg[17:16] == 2'd0) return swap ? ARX : ARY;
      else                    return 13'd0;
   endfunction

   // ---------------------------------------------------------------------------------------
   // Input synchronisers
   // ---------------------------------------------------------------------------------------
   logic [SW-1:0] stat_m, stat_s;
   logic          pause_m, pause_s, pause_l;
   logic          vb_l;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stat_m  <= RST_CFG;
         stat_s  <= RST_CFG;
         pause_m <= 1'b0;
         pause_s <= 1'b0;
         pause_l <= 1'b0;
         vb_l    <= 1'b0;
      end else begin
         stat_m  <= status;
         stat_s  <= stat_m;
         pause_m <= game_pause;
         pause_s <= pause_m;
         pause_l <= pause_s;
         vb_l    <= vb;
      end
   end

   logic btn_rise, vb_rise;
   assign btn_rise = pause_s & ~pause_l;
   assign vb_rise  = vb & ~vb_l;

   // ---------------------------------------------------------------------------------------
   // Settle FSM: commit a status value only after it has been stable for STABLE cycles
   // ---------------------------------------------------------------------------------------
   typedef enum logic [0:0] {StIdle, StSettle} settle_e;

   settle_e       sst;
   logic [SW-1:0] cand;
   logic [CW-1:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sst     <= StIdle;
         cand    <= RST_CFG;
         cnt     <= '0;
         dip_cfg <= RST_CFG;
         cfg_upd <= 1'b0;
      end else begin
         cfg_upd <= 1'b0;
         case (sst)
            StIdle: begin
               if (stat_s != dip_cfg) begin
                  sst  <= StSettle;
                  cand <= stat_s;
                  cnt  <= '0;
               end
            end
            StSettle: begin
               if (stat_s != cand) begin
                  cand <= stat_s;
                  cnt  <= '0;
               end else if (cnt == CNT_LAST) begin
                  // A glitch that returned to the old value still commits, silently.
                  dip_cfg <= cand;
                  cfg_upd <= (cand != dip_cfg);
                  sst     <= StIdle;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            default: sst <= StIdle;
         endcase
      end
   end

   // ---------------------------------------------------------------------------------------
   // Registered derived settings
   // ---------------------------------------------------------------------------------------
   logic tate;
   assign tate = core_mod[0] & ~dip_cfg[2];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // Reset values assume a horizontal game until core_mod is sampled.
         dip_flip    <= RST_CFG[1];
         rotate      <= {~RST_CFG[1], 1'b0};
         hdmi_arx    <= arx_of(RST_CFG, 1'b0);
         hdmi_ary    <= ary_of(RST_CFG, 1'b0);
         dip_fxlevel <= 2'b10 ^ RST_CFG[7:6];
         snd_en      <= snd_of(RST_CFG);
      end else begin
         dip_flip    <= dip_cfg[1];
         rotate      <= {~dip_cfg[1], tate};
         hdmi_arx    <= arx_of(dip_cfg, tate);
         hdmi_ary    <= ary_of(dip_cfg, tate);
         dip_fxlevel <= 2'b10 ^ dip_cfg[7:6];
         snd_en      <= snd_of(dip_cfg);
      end
   end

   // ---------------------------------------------------------------------------------------
   // Pause FSM: button requests are applied at the next vb rising edge
   // ---------------------------------------------------------------------------------------
   typedef enum logic [1:0] {StRun, StPendP, StPaused, StPendR} pause_e;

   pause_e pst, pst_nx;
   logic   halt_nx;

   // A button edge always takes priority over a simultaneous vb edge.
   always_comb begin
      pst_nx = pst;
      unique case (pst)
         StRun:    if (btn_rise) pst_nx = StPendP;
         StPendP:  if (btn_rise) pst_nx = StRun;
                   else if (vb_rise) pst_nx = StPaused;
         StPaused: if (btn_rise) pst_nx = StPendR;
         StPendR:  if (btn_rise) pst_nx = StPaused;
                   else if (vb_rise) pst_nx = StRun;
      endcase
   end

`ifdef JTFRAME_DIP_OSDPAUSE_EN
   logic osd_m, osd_s;
   logic unused_in;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         osd_m <= 1'b0;
         osd_s <= 1'b0;
      end else begin
         osd_m <= osd_shown;
         osd_s <= osd_m;
      end
   end

   assign halt_nx   = (pst_nx == StPaused) || (pst_nx == StPendR) || osd_s;
   assign unused_in = ^core_mod[6:1];
`else
   logic unused_in;

   assign halt_nx   = (pst_nx == StPaused) || (pst_nx == StPendR);
   assign unused_in = ^{core_mod[6:1], osd_shown};
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pst       <= StRun;
         dip_pause <= 1'b1;
      end else begin
         pst       <= pst_nx;
         dip_pause <= ~halt_nx;
      end
   end

endmodule

// File: tb/tb_jtframe_dipctl.sv
module tb_jtframe_dipctl;

   localparam int unsigned SW = 64;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [SW-1:0] status = '0;
   logic [6:0]    core_mod = '0;
   logic          game_pause = 1'b0;
   logic          vb = 1'b0;
   logic          osd_shown = 1'b0;

   logic [SW-1:0] dip_cfg;
   logic          cfg_upd;
   logic          dip_flip;
   logic [1:0]    rotate;
   logic [12:0]   hdmi_arx;
   logic [12:0]   hdmi_ary;
   logic [1:0]    dip_fxlevel;
   logic [1:0]    snd_en;
   logic          dip_pause;

   int n_vec  = 0;
   int n_miss = 0;

   jtframe_dipctl dut (
      .clk         (clk),
      .rst         (rst),
      .status      (status),
      .core_mod    (core_mod),
      .game_pause  (game_pause),
      .vb          (vb),
      .osd_shown   (osd_shown),
      .dip_cfg     (dip_cfg),
      .cfg_upd     (cfg_upd),
      .dip_flip    (dip_flip),
      .rotate      (rotate),
      .hdmi_arx    (hdmi_arx),
      .hdmi_ary    (hdmi_ary),
      .dip_fxlevel (dip_fxlevel),
      .snd_en      (snd_en),
      .dip_pause   (dip_pause)
   );

   always #5 clk = ~clk;

   // Advance n rising edges and settle 1 ns past the last one.
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Waits (bounded) for a commit pulse, then one more edge for the derived outputs.
   task automatic wait_commit(input string tag);
      bit got;
      got = 1'b0;
      for (int i = 0; i < 40 && !got; i++) begin
         @(posedge clk);
         #1;
         if (cfg_upd === 1'b1) got = 1'b1;
      end
      n_vec++;
      if (!got) begin
         n_miss++;
         $display("FAIL %s_commit: got no cfg_upd, want a pulse within 40 cycles", tag);
      end
      tick(1);
   endtask

   task automatic press();
      game_pause = 1'b1;
      tick(4);
      game_pause = 1'b0;
      tick(4);
   endtask

   task automatic vb_pulse();
      vb = 1'b1;
      tick(3);
      vb = 1'b0;
      tick(3);
   endtask

   task automatic test_reset();
      #1 rst = 1'b1;
      #2;
      n_vec++; if (dip_cfg !== 64'h0) begin n_miss++;
         $display("FAIL reset_cfg: got %h want %h", dip_cfg, 64'h0); end
      n_vec++; if (cfg_upd !== 1'b0) begin n_miss++;
         $display("FAIL reset_upd: got %b want 0", cfg_upd); end
      n_vec++; if (dip_pause !== 1'b1) begin n_miss++;
         $display("FAIL reset_pause: got %b want 1", dip_pause); end
      n_vec++; if (snd_en !== 2'b11) begin n_miss++;
         $display("FAIL reset_snd: got %b want 11", snd_en); end
      n_vec++; if (dip_fxlevel !== 2'b10) begin n_miss++;
         $display("FAIL reset_fx: got %b want 10", dip_fxlevel); end
      n_vec++; if (hdmi_arx !== 13'd4 || hdmi_ary !== 13'd3) begin n_miss++;
         $display("FAIL reset_ar: got %0d:%0d want 4:3", hdmi_arx, hdmi_ary); end
      n_vec++; if (rotate !== 2'b10 || dip_flip !== 1'b0) begin n_miss++;
         $display("FAIL reset_rot: got rot=%b flip=%b want rot=10 flip=0", rotate, dip_flip); end
      tick(3);
      rst = 1'b0;
      tick(3);
   endtask

   task automatic test_settle();
      status = 64'h40;
      for (int e = 0; e < 20; e++) begin
         @(posedge clk);
         #1;
         n_vec++; if (cfg_upd !== (e == 18)) begin n_miss++;
            $display("FAIL settle_upd edge %0d: got %b want %b", e, cfg_upd, (e == 18)); end
         if (e == 17) begin
            n_vec++; if (dip_cfg !== 64'h0) begin n_miss++;
               $display("FAIL settle_early: got %h want 0", dip_cfg); end
         end
         if (e == 18) begin
            n_vec++; if (dip_cfg !== 64'h40 || dip_fxlevel !== 2'b10) begin n_miss++;
               $display("FAIL settle_commit: got cfg=%h fx=%b want cfg=40 fx=10",
                        dip_cfg, dip_fxlevel); end
         end
         if (e == 19) begin
            n_vec++; if (dip_fxlevel !== 2'b11) begin n_miss++;
               $display("FAIL settle_fx: got %b want 11", dip_fxlevel); end
         end
      end
   endtask

   task automatic test_glitch();
      bit seen;
      int at;
      seen = 1'b0;
      for (int k = 0; k < 6; k++) begin
         status = (k % 2 == 0) ? 64'h140 : 64'h40;
         for (int j = 0; j < 10; j++) begin
            tick(1);
            if (cfg_upd !== 1'b0) seen = 1'b1;
         end
      end
      n_vec++; if (seen || dip_cfg !== 64'h40) begin n_miss++;
         $display("FAIL glitch_hold: got upd_seen=%b cfg=%h want 0, 40", seen, dip_cfg); end
      status = 64'h140;
      at = -1;
      for (int e = 0; e < 25; e++) begin
         @(posedge clk);
         #1;
         if (cfg_upd === 1'b1 && at < 0) at = e;
      end
      n_vec++; if (at != 18) begin n_miss++;
         $display("FAIL glitch_commit_edge: got %0d want 18", at); end
      n_vec++; if (snd_en !== 2'b10 || dip_cfg !== 64'h140) begin n_miss++;
         $display("FAIL glitch_snd: got snd=%b cfg=%h want 10, 140", snd_en, dip_cfg); end
   endtask

   task automatic test_aspect();
      core_mod = 7'd1;
      tick(2);
      n_vec++; if (rotate !== 2'b11 || hdmi_arx !== 13'd3 || hdmi_ary !== 13'd4) begin n_miss++;
         $display("FAIL aspect_tate: got rot=%b ar=%0d:%0d want 11 3:4",
                  rotate, hdmi_arx, hdmi_ary); end
      status = 64'h30140;
      wait_commit("ar3");
      n_vec++; if (hdmi_arx !== 13'd2 || hdmi_ary !== 13'd0 || rotate !== 2'b11) begin
         n_miss++;
         $display("FAIL aspect_ar3: got rot=%b ar=%0d:%0d want 11 2:0",
                  rotate, hdmi_arx, hdmi_ary); end
      status = 64'h30146;
      wait_commit("flip");
      n_vec++; if (rotate !== 2'b00 || dip_flip !== 1'b1 || hdmi_arx !== 13'd2) begin
         n_miss++;
         $display("FAIL aspect_flip: got rot=%b flip=%b arx=%0d want 00 1 2",
                  rotate, dip_flip, hdmi_arx); end
      status = 64'h10140;
      wait_commit("ar1");
      n_vec++; if (hdmi_arx !== 13'd0 || hdmi_ary !== 13'd0 || rotate !== 2'b11) begin
         n_miss++;
         $display("FAIL aspect_ar1: got rot=%b ar=%0d:%0d want 11 0:0",
                  rotate, hdmi_arx, hdmi_ary); end
   endtask

   task automatic test_pause();
      press();
      n_vec++; if (dip_pause !== 1'b1) begin n_miss++;
         $display("FAIL pause_midframe: got %b want 1", dip_pause); end
      vb_pulse();
      n_vec++; if (dip_pause !== 1'b0) begin n_miss++;
         $display("FAIL pause_at_vb: got %b want 0", dip_pause); end
      press();
      n_vec++; if (dip_pause !== 1'b0) begin n_miss++;
         $display("FAIL pause_pend_release: got %b want 0", dip_pause); end
      vb_pulse();
      n_vec++; if (dip_pause !== 1'b1) begin n_miss++;
         $display("FAIL pause_resume: got %b want 1", dip_pause); end
      press();
      press();
      vb_pulse();
      n_vec++; if (dip_pause !== 1'b1) begin n_miss++;
         $display("FAIL pause_cancel: got %b want 1", dip_pause); end
      // Button edge and vb edge on the same cycle while running.
      game_pause = 1'b1;
      tick(2);
      vb = 1'b1;
      tick(1);
      n_vec++; if (dip_pause !== 1'b1) begin n_miss++;
         $display("FAIL pause_coincide_now: got %b want 1", dip_pause); end
      tick(3);
      vb = 1'b0;
      game_pause = 1'b0;
      tick(4);
      vb_pulse();
      n_vec++; if (dip_pause !== 1'b0) begin n_miss++;
         $display("FAIL pause_coincide_next_vb: got %b want 0", dip_pause); end
      press();
      vb_pulse();
      n_vec++; if (dip_pause !== 1'b1) begin n_miss++;
         $display("FAIL pause_unpause: got %b want 1", dip_pause); end
      // Cancel press coinciding with vb while pending: button must win.
      press();
      game_pause = 1'b1;
      tick(2);
      vb = 1'b1;
      tick(1);
      tick(3);
      vb = 1'b0;
      game_pause = 1'b0;
      tick(4);
      vb_pulse();
      n_vec++; if (dip_pause !== 1'b1) begin n_miss++;
         $display("FAIL pause_btn_priority: got %b want 1", dip_pause); end
   endtask

`ifdef JTFRAME_DIP_OSDPAUSE_EN
   task automatic test_osd();
      osd_shown = 1'b1;
      tick(2);
      n_vec++; if (dip_pause !== 1'b1) begin n_miss++;
         $display("FAIL osd_early: got %b want 1", dip_pause); end
      tick(1);
      n_vec++; if (dip_pause !== 1'b0) begin n_miss++;
         $display("FAIL osd_hold: got %b want 0", dip_pause); end
      osd_shown = 1'b0;
      tick(3);
      n_vec++; if (dip_pause !== 1'b1) begin n_miss++;
         $display("FAIL osd_release: got %b want 1", dip_pause); end
   endtask
`endif

   task automatic test_async_reset();
      bit seen;
      status = 64'h5;
      tick(10);
      rst = 1'b1;
      #1;
      n_vec++; if (dip_cfg !== 64'h0 || cfg_upd !== 1'b0) begin n_miss++;
         $display("FAIL arst_cfg: got cfg=%h upd=%b want 0 0", dip_cfg, cfg_upd); end
      n_vec++; if (dip_fxlevel !== 2'b10 || dip_pause !== 1'b1) begin n_miss++;
         $display("FAIL arst_outs: got fx=%b pause=%b want 10 1", dip_fxlevel, dip_pause); end
      status = 64'h0;
      tick(2);
      rst = 1'b0;
      seen = 1'b0;
      for (int e = 0; e < 25; e++) begin
         tick(1);
         if (cfg_upd !== 1'b0) seen = 1'b1;
      end
      n_vec++; if (seen || dip_cfg !== 64'h0) begin n_miss++;
         $display("FAIL arst_quiet: got upd_seen=%b cfg=%h want 0 0", seen, dip_cfg); end
   endtask

   initial begin
      test_reset();
      test_settle();
      test_glitch();
      test_aspect();
      test_pause();
`ifdef JTFRAME_DIP_OSDPAUSE_EN
      test_osd();
`endif
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
